// File: rtl/conv2d_window_feeder_pkg.sv
// Shared constants and state encoding for the conv2d window feeder.
package conv_pkg;

  localparam int KERNEL          = 3;
  localparam int IN_CH           = 3;
  localparam int NUM_INPUTS      = KERNEL * KERNEL * IN_CH;
  localparam int DEFAULT_BITSIZE = 14;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } feeder_state_e;

  // Flat position of one sample inside the 3x3x3 window bus.
  function automatic int unsigned elem_index(input int unsigned ch,
                                             input int unsigned ky,
                                             input int unsigned kx);
    return ch * KERNEL * KERNEL + ky * KERNEL + kx;
  endfunction

endpackage

// File: rtl/conv2d_window_feeder_if.sv
// Pixel stream handshake between a pixel source and the window feeder.
interface conv2d_window_feeder_if #(
  parameter int bitsize = 14
);
  logic                   pix_valid;
  logic [bitsize*3-1:0]   pix_in;
  logic                   pix_ready;

  modport master (output pix_valid, output pix_in, input pix_ready);
  modport slave  (input pix_valid, input pix_in, output pix_ready);
endinterface

// File: rtl/conv2d_window_feeder_line_buffer.sv
// One image row of delay: the output is the pixel accepted IMG_W enables ago.
// Contents are deliberately not reset; rows 0 and 1 of every frame refill them.
module conv2d_line_buffer
  import conv_pkg::*;
#(
  parameter int width = DEFAULT_BITSIZE * IN_CH,
  parameter int IMG_W = 16
) (
  input  logic             clk,
  input  logic             en,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout
);

  logic [width-1:0] mem [IMG_W];

  assign dout = mem[IMG_W-1];

  // Shift one pixel in per accepted pixel.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int unsigned i = 1; i < IMG_W; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

endmodule

// File: rtl/conv2d_window_feeder.sv
// Raster pixel stream to 3x3x3 sliding window feeder for a conv2d pipeline.
// Optional macro CONV2D_FEEDER_STRIDE2_EN: emit windows at stride 2 only.
module conv2d_window_feeder
  import conv_pkg::*;
#(
  parameter int bitsize = DEFAULT_BITSIZE,
  parameter int IMG_W   = 16,
  parameter int IMG_H   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  conv2d_window_feeder_if.slave         pix,
  output logic [bitsize*NUM_INPUTS-1:0] data_out,
  output logic                          start_flag,
  output logic                          frame_done,
  output logic                          busy
);

  localparam int PW = bitsize * IN_CH;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  feeder_state_e state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          ready_q;
  logic          accept;
  logic          emit;
  logic          last_col;
  logic          last_row;
  logic [PW-1:0] lb1_out;
  logic [PW-1:0] lb2_out;
  logic [PW-1:0] row_in  [KERNEL];
  logic [PW-1:0] win     [KERNEL][KERNEL];
  logic [PW-1:0] win_nxt [KERNEL][KERNEL];
  logic [bitsize*NUM_INPUTS-1:0] window_flat;

  assign pix.pix_ready = ready_q;
  assign accept        = pix.pix_valid & ready_q;
  assign last_col      = (col == CW'(IMG_W - 1));
  assign last_row      = (row == RW'(IMG_H - 1));

`ifdef CONV2D_FEEDER_STRIDE2_EN
  // r-2 and c-2 even is the same as r and c even once both are at least 2.
  assign emit = accept && (row >= RW'(2)) && (col >= CW'(2)) && !row[0] && !col[0];
`else
  assign emit = accept && (row >= RW'(2)) && (col >= CW'(2));
`endif

  conv2d_line_buffer #(.width(PW), .IMG_W(IMG_W)) u_lb1 (
    .clk  (clk),
    .en   (accept),
    .din  (pix.pix_in),
    .dout (lb1_out)
  );

  conv2d_line_buffer #(.width(PW), .IMG_W(IMG_W)) u_lb2 (
    .clk  (clk),
    .en   (accept),
    .din  (lb1_out),
    .dout (lb2_out)
  );

  // Window as it will look after this pixel: shift left, new column at kx=2.
  always_comb begin
    row_in[0] = lb2_out;
    row_in[1] = lb1_out;
    row_in[2] = pix.pix_in;
    for (int unsigned ky = 0; ky < KERNEL; ky++) begin
      win_nxt[ky][0] = win[ky][1];
      win_nxt[ky][1] = win[ky][2];
      win_nxt[ky][2] = row_in[ky];
    end
  end

  // Repack the next window into the channel-major output bus.
  always_comb begin
    window_flat = '0;
    for (int unsigned ch = 0; ch < IN_CH; ch++) begin
      for (int unsigned ky = 0; ky < KERNEL; ky++) begin
        for (int unsigned kx = 0; kx < KERNEL; kx++) begin
          window_flat[bitsize*elem_index(ch, ky, kx) +: bitsize] = win_nxt[ky][kx][bitsize*ch +: bitsize];
        end
      end
    end
  end

  // Per-row 3-column shift registers; stale contents never reach an emitted window.
  always_ff @(posedge clk) begin
    if (accept) begin
      win <= win_nxt;
    end
  end

  // Frame FSM with counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      row        <= '0;
      col        <= '0;
      ready_q    <= 1'b0;
      busy       <= 1'b0;
      start_flag <= 1'b0;
      frame_done <= 1'b0;
      data_out   <= '0;
    end else begin
      start_flag <= emit;
      frame_done <= 1'b0;
      if (emit) begin
        data_out <= window_flat;
      end
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state   <= ST_FILL;
            row     <= '0;
            col     <= '0;
            ready_q <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_FILL, ST_STREAM: begin
          if (accept) begin
            if (last_col) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (state == ST_FILL && row == RW'(2) && col == '0) begin
              state <= ST_STREAM;
            end
            if (last_col && last_row) begin
              state      <= ST_IDLE;
              row        <= '0;
              col        <= '0;
              ready_q    <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_window_feeder.sv
// Bench for conv2d_window_feeder: 16x16 frames against a window scoreboard,
// plus a 3x3 instance for the single-window corner case.
module tb_conv2d_window_feeder;
  import conv_pkg::*;

  localparam int BS = 14;
  localparam int DW = BS * 27;
  localparam int PW = BS * 3;
`ifdef CONV2D_FEEDER_STRIDE2_EN
  localparam int FULL_WIN = 49;
  localparam int PART_WIN = 3;
`else
  localparam int FULL_WIN = 196;
  localparam int PART_WIN = 6;
`endif

  typedef logic [DW-1:0] win_t;
  typedef struct {
    int gap_pct;
    int reset_after;
    bit stray;
    int exp_win;
  } vec_t;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic fs_a = 1'b0;
  logic fs_b = 1'b0;
  win_t dout_a, dout_b;
  logic sf_a, sf_b, fd_a, fd_b, busy_a, busy_b;

  int   tests = 0;
  int   fails = 0;
  win_t sb[$];
  win_t last_exp = '0;
  win_t first_win = '0;
  win_t mon_e;
  int   frame_wins = 0;
  int   b_wins = 0;
  vec_t vec [5];

  conv2d_window_feeder_if #(.bitsize(BS)) if_a ();
  conv2d_window_feeder_if #(.bitsize(BS)) if_b ();

  conv2d_window_feeder #(.bitsize(BS), .IMG_W(16), .IMG_H(16)) u_dut_a (
    .clk(clk), .rst(rst), .frame_start(fs_a), .pix(if_a),
    .data_out(dout_a), .start_flag(sf_a), .frame_done(fd_a), .busy(busy_a)
  );

  conv2d_window_feeder #(.bitsize(BS), .IMG_W(3), .IMG_H(3)) u_dut_b (
    .clk(clk), .rst(rst), .frame_start(fs_b), .pix(if_b),
    .data_out(dout_b), .start_flag(sf_b), .frame_done(fd_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] pixel(input int r, input int c);
    logic [PW-1:0] p;
    for (int ch = 0; ch < 3; ch++) p[ch*BS +: BS] = BS'(ch*4096 + r*16 + c);
    return p;
  endfunction

  function automatic win_t exp_window(input int r0, input int c0);
    win_t w;
    for (int ch = 0; ch < 3; ch++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          w[(ch*9 + ky*3 + kx)*BS +: BS] = BS'(ch*4096 + (r0+ky)*16 + (c0+kx));
    return w;
  endfunction

  function automatic bit emits(input int r, input int c);
    if (r < 2 || c < 2) return 1'b0;
`ifdef CONV2D_FEEDER_STRIDE2_EN
    return ((r-2) % 2 == 0) && ((c-2) % 2 == 0);
`else
    return 1'b1;
`endif
  endfunction

  // Scoreboard consumer for the 16x16 instance, plus data_out hold check.
  always @(negedge clk) begin
    if (!rst) begin
      last_exp = '0;
    end else if (sf_a) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_window: got start_flag=1 want 0");
      end else begin
        mon_e = sb.pop_front();
        check("window", dout_a, mon_e);
        last_exp = mon_e;
        if (frame_wins == 0) first_win = dout_a;
        frame_wins++;
      end
    end else begin
      check("hold", dout_a, last_exp);
    end
  end

  always @(negedge clk) begin
    if (rst && sf_b) b_wins++;
  end

  task automatic run_frame(input int gap_pct, input int reset_after, input bit stray, input int exp_win);
    int n;
    int accepted;
    bit last_emit;
    accepted   = 0;
    last_emit  = 1'b0;
    frame_wins = 0;
    first_win  = '0;
    fs_a = 1'b1;
    tick();
    fs_a = 1'b0;
    check("busy_after_start", busy_a, 1);
    check("ready_in_fill", if_a.pix_ready, 1);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        if (reset_after >= 0 && accepted == reset_after) begin
          if_a.pix_valid = 1'b0;
          tick();
          tick();
          check("partial_windows", frame_wins, exp_win);
          check("sb_drained", sb.size(), 0);
          rst = 1'b0;
          #1;
          check("rst_data_out", dout_a, 0);
          check("rst_start_flag", sf_a, 0);
          check("rst_frame_done", fd_a, 0);
          check("rst_busy", busy_a, 0);
          check("rst_ready", if_a.pix_ready, 0);
          repeat (3) tick();
          rst = 1'b1;
          tick();
          check("idle_after_reset", busy_a, 0);
          return;
        end
        while ($urandom_range(99) < gap_pct) begin
          if_a.pix_valid = 1'b0;
          if_a.pix_in    = PW'({$urandom, $urandom});
          tick();
        end
        if (stray && r == 6 && c == 5) fs_a = 1'b1;
        if_a.pix_valid = 1'b1;
        if_a.pix_in    = pixel(r, c);
        n = 0;
        while (!if_a.pix_ready && n < 20) begin
          tick();
          n++;
        end
        if (n == 20) begin
          tests++;
          fails++;
          $display("FAIL accept_timeout: got pix_ready=0 want 1 at r=%0d c=%0d", r, c);
          if_a.pix_valid = 1'b0;
          fs_a = 1'b0;
          return;
        end
        last_emit = emits(r, c);
        if (last_emit) sb.push_back(exp_window(r-2, c-2));
        tick();
        fs_a = 1'b0;
        accepted++;
      end
    end
    if_a.pix_valid = 1'b0;
    check("frame_done_pulse", fd_a, 1);
    check("last_start_flag", sf_a, last_emit);
    check("idle_after_frame", busy_a, 0);
    check("ready_low_idle", if_a.pix_ready, 0);
    tick();
    check("frame_done_single", fd_a, 0);
    check("start_flag_clear", sf_a, 0);
    tick();
    check("window_count", frame_wins, exp_win);
    check("sb_empty", sb.size(), 0);
    check("first_k0", first_win[BS-1:0], 0);
    check("first_k26", first_win[26*BS +: BS], 8192 + 2*16 + 2);
  endtask

  initial begin
    int n;
    vec[0] = '{gap_pct: 0,  reset_after: -1, stray: 1'b0, exp_win: FULL_WIN};
    vec[1] = '{gap_pct: 50, reset_after: -1, stray: 1'b0, exp_win: FULL_WIN};
    vec[2] = '{gap_pct: 0,  reset_after: 40, stray: 1'b0, exp_win: PART_WIN};
    vec[3] = '{gap_pct: 0,  reset_after: -1, stray: 1'b0, exp_win: FULL_WIN};
    vec[4] = '{gap_pct: 25, reset_after: -1, stray: 1'b1, exp_win: FULL_WIN};

    if_a.pix_valid = 1'b0;
    if_a.pix_in    = '0;
    if_b.pix_valid = 1'b0;
    if_b.pix_in    = '0;

    #12;
    check("reset_data_out", dout_a, 0);
    check("reset_start_flag", sf_a, 0);
    check("reset_frame_done", fd_a, 0);
    check("reset_busy", busy_a, 0);
    check("reset_ready", if_a.pix_ready, 0);
    rst = 1'b1;
    tick();

    // Pixels offered while idle must be refused.
    for (int i = 0; i < 5; i++) begin
      if_a.pix_valid = 1'b1;
      if_a.pix_in    = pixel(0, i);
      tick();
      check("idle_ready", if_a.pix_ready, 0);
      check("idle_busy", busy_a, 0);
    end
    if_a.pix_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_frame(vec[i].gap_pct, vec[i].reset_after, vec[i].stray, vec[i].exp_win);
    end

    // 3x3 image: the single window coincides with frame_done.
    fs_b = 1'b1;
    tick();
    fs_b = 1'b0;
    check("b_ready", if_b.pix_ready, 1);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if_b.pix_valid = 1'b1;
        if_b.pix_in    = pixel(r, c);
        n = 0;
        while (!if_b.pix_ready && n < 20) begin
          tick();
          n++;
        end
        if (n == 20) begin
          tests++;
          fails++;
          $display("FAIL b_accept_timeout: got pix_ready=0 want 1 at r=%0d c=%0d", r, c);
        end
        tick();
      end
    end
    if_b.pix_valid = 1'b0;
    check("b_start_flag", sf_b, 1);
    check("b_frame_done", fd_b, 1);
    check("b_window", dout_b, exp_window(0, 0));
    check("b_idle", busy_b, 0);
    tick();
    check("b_start_flag_clear", sf_b, 0);
    check("b_frame_done_clear", fd_b, 0);
    check("b_hold", dout_b, exp_window(0, 0));
    tick();
    check("b_window_count", b_wins, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion want summary within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv2d_window_feeder.md
CONV2D_WINDOW_FEEDER -- requirements
Module: conv2d_window_feeder

Interface
REQ-001 SHALL have parameter bitsize, default 14: width of one fixed-point sample.
REQ-002 SHALL have parameter IMG_W, default 16: image width in pixels, minimum 3.
REQ-003 SHALL have parameter IMG_H, default 16: image height in pixels, minimum 3.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port frame_start, input, 1: a one-cycle pulse that starts a frame.
REQ-007 SHALL have port pix_valid, input, 1: a pixel is offered.
REQ-008 SHALL have port pix_in, input, bitsize*3: pixel; channel c occupies bits [bitsize*(c+1)-1 : bitsize*c].
REQ-009 SHALL have port pix_ready, output, 1: the block accepts a pixel.
REQ-010 SHALL have port data_out, output, bitsize*27: 3x3x3 window; element k = c*9+ky*3+kx occupies bits [bitsize*(k+1)-1 : bitsize*k]; ky=0 is the top row and kx=0 is the left column.
REQ-011 SHALL have port start_flag, output, 1: one-cycle pulse qualifying data_out, driven into the conv2d start_flag.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse after the last pixel of the frame.
REQ-013 SHALL have port busy, output, 1: high in all states other than IDLE.

Function
REQ-014 SHALL implement states IDLE, FILL and STREAM.
REQ-015 IDLE -> FILL on frame_start; pix_ready SHALL be 0 in IDLE, and pix_valid in IDLE SHALL be ignored.
REQ-016 A pixel SHALL be accepted only on a cycle with pix_valid=1 and pix_ready=1; pixels arrive in raster order; row counter r and column counter c SHALL advance per accepted pixel, and c SHALL wrap at IMG_W-1 to 0 while r increments.
REQ-017 FILL -> STREAM when row 2, column 0 is accepted.
REQ-018 Two line buffers of IMG_W pixels SHALL hold rows r-1 and r-2, and a 3-column shift register per row SHALL form the window.
REQ-019 When pixel (r,c) is accepted with r>=2 and c>=2, data_out SHALL present the window with rows r-2..r and columns c-2..c on the next cycle, with start_flag=1 for exactly that cycle.
REQ-020 No window SHALL be emitted across a row wrap (c<2).
REQ-021 Data SHALL be passed through bit-exact, with no arithmetic performed.
REQ-022 Acceptance of pixel (IMG_H-1, IMG_W-1) SHALL produce a frame_done pulse on the next cycle (coincident with the last start_flag) and a return to IDLE.
REQ-023 pix_ready SHALL be 1 in FILL and STREAM, with no backpressure; one window per cycle matches the conv2d pipeline throughput.
REQ-024 frame_start SHALL be ignored while busy=1.
REQ-025 data_out SHALL hold its last value when start_flag=0.

Reset
REQ-026 While rst=0, the state SHALL be IDLE, the counters 0, and data_out, start_flag, frame_done, busy and pix_ready all 0.
REQ-027 Reset mid-frame SHALL abort the frame with no further start_flag; line buffer contents need not be cleared.

Configuration
REQ-028 With macro CONV2D_FEEDER_STRIDE2_EN defined, a window SHALL be emitted only when (r-2) and (c-2) are both even, which is stride 2, as for the MobileNetV3 stem; the default 16x16 image then yields 7x7 = 49 windows.
REQ-029 Without CONV2D_FEEDER_STRIDE2_EN, stride 1 SHALL apply, yielding (IMG_W-2)*(IMG_H-2) windows, i.e. 196 by default.
REQ-030 The macro SHALL affect only the window-emit qualification; latency and frame_done timing SHALL be unchanged.

Structure
REQ-031 Shared package conv_pkg SHALL hold KERNEL=3, IN_CH=3, NUM_INPUTS=27, the default bitsize, and the state encoding.
REQ-032 One sub-module, conv2d_line_buffer, SHALL be a parameterised width x IMG_W shift/circular buffer, instantiated twice.

Verification
REQ-033 Scenario: a 16x16 frame with channel c of pixel (r,c') = c*4096+r*16+c', stride 1 -> 196 start_flag pulses; the first window element k=0 is 0 and element k=26 equals 8192+2*16+2; frame_done is coincident with the last pulse.
REQ-034 Scenario: the same frame with CONV2D_FEEDER_STRIDE2_EN defined -> 49 pulses, with window origins at rows and columns 0,2,...,12.
REQ-035 Scenario: pix_valid toggled randomly at 50% -> the window contents are identical to REQ-033 and only the timing stretches.
REQ-036 Scenario: rst driven low after 40 accepted pixels -> all outputs 0 within the same cycle, no further start_flag, and a subsequent full frame gives REQ-033 results.
REQ-037 Scenario: frame_start pulsed mid-frame and pix_valid asserted in IDLE -> both ignored, pix_ready=0 in IDLE, and the window count is unchanged.
REQ-038 Scenario: IMG_W=3, IMG_H=3 -> exactly one start_flag, with frame_done on the same cycle.
